// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, receiver state encoding and the parity helper
// used by both the transmit and receive engines.
package uart_pkg;

  localparam int FRAME_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // Parity bit that makes ones(data, P) odd.
  function automatic logic odd_parity(input logic [FRAME_DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/receiver_engine_if.sv
// Receive-side link bundle: tick/line inputs toward the engine, character and status back out.
interface receiver_engine_if;
  import uart_pkg::*;

  logic                       sample_tick;
  logic                       RX;
  logic [FRAME_DATA_BITS-1:0] data_out;
  logic                       rx_valid;
  logic                       parity_err;
  logic                       frame_err;
  logic                       rx_busy;

  modport master (
    output sample_tick, RX,
    input  data_out, rx_valid, parity_err, frame_err, rx_busy
  );

  modport slave (
    input  sample_tick, RX,
    output data_out, rx_valid, parity_err, frame_err, rx_busy
  );
endinterface

// File: rtl/receiver_engine_rx_sync.sv
// Multi-flop synchronizer for the asynchronous RX line; resets to the idle (high) level
// so that releasing reset never looks like a start bit.
module rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the raw line through the synchronizer chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/receiver_engine.sv
// UART receive engine: oversampled start/data/parity/stop recovery with odd-parity and
// framing checks; one rx_valid pulse per completed frame.
module receiver_engine
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              reset,
  receiver_engine_if.slave bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] ONE  = TW'(1);

  logic                       rx_s;
  rx_state_t                  state_r;
  logic [TW-1:0]              tcnt_r;
  logic [2:0]                 bcnt_r;
  logic [FRAME_DATA_BITS-1:0] shift_r;
  logic                       p_bad_r;
  logic [FRAME_DATA_BITS-1:0] data_out_r;
  logic                       rx_valid_r;
  logic                       parity_err_r;
  logic                       frame_err_r;
  logic                       rx_busy_r;

  rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.RX),
    .q     (rx_s)
  );

  // Frame FSM with tick/bit counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      tcnt_r       <= {TW{1'b0}};
      bcnt_r       <= 3'd0;
      shift_r      <= {FRAME_DATA_BITS{1'b0}};
      p_bad_r      <= 1'b0;
      data_out_r   <= {FRAME_DATA_BITS{1'b0}};
      rx_valid_r   <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      rx_busy_r    <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if (bus.sample_tick) begin
        case (state_r)
          IDLE: begin
            if (!rx_s) begin
              state_r   <= START;
              tcnt_r    <= {TW{1'b0}};
              rx_busy_r <= 1'b1;
            end
          end
          START: begin
            // Mid-bit recheck rejects glitches shorter than half a bit.
            if (tcnt_r == HALF) begin
              if (rx_s) begin
                state_r   <= IDLE;
                rx_busy_r <= 1'b0;
              end else begin
                tcnt_r  <= {TW{1'b0}};
                bcnt_r  <= 3'd0;
                state_r <= DATA;
              end
            end else begin
              tcnt_r <= tcnt_r + ONE;
            end
          end
          DATA: begin
            if (tcnt_r == FULL) begin
              tcnt_r  <= {TW{1'b0}};
              shift_r <= {rx_s, shift_r[FRAME_DATA_BITS-1:1]};
              if (bcnt_r == 3'd7) begin
                state_r <= PARITY;
              end else begin
                bcnt_r <= bcnt_r + 3'd1;
              end
            end else begin
              tcnt_r <= tcnt_r + ONE;
            end
          end
          PARITY: begin
            if (tcnt_r == FULL) begin
              tcnt_r  <= {TW{1'b0}};
              p_bad_r <= (odd_parity(shift_r) != rx_s);
              state_r <= STOP;
            end else begin
              tcnt_r <= tcnt_r + ONE;
            end
          end
          STOP: begin
            if (tcnt_r == FULL) begin
              tcnt_r       <= {TW{1'b0}};
              data_out_r   <= shift_r;
              parity_err_r <= p_bad_r;
              frame_err_r  <= ~rx_s;
              rx_valid_r   <= 1'b1;
              if (rx_s) begin
                state_r   <= IDLE;
                rx_busy_r <= 1'b0;
              end else begin
                state_r <= BREAK;
              end
            end else begin
              tcnt_r <= tcnt_r + ONE;
            end
          end
          BREAK: begin
            if (rx_s) begin
              state_r   <= IDLE;
              rx_busy_r <= 1'b0;
            end
          end
          default: begin
            state_r   <= IDLE;
            rx_busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_out   = data_out_r;
  assign bus.rx_valid   = rx_valid_r;
  assign bus.parity_err = parity_err_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.rx_busy    = rx_busy_r;

endmodule

// File: tb/tb_receiver_engine.sv
// Self-checking bench for receiver_engine: table of single frames, directed corner
// sequences, and random frames scored against a frame-level reference model.
module tb_receiver_engine;

  localparam int BIT_CLKS = 64;   // 16 ticks per bit, one tick every 4 clocks

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rec_t;

  typedef struct {
    logic [7:0] data;
    logic       p_ok;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   tick_cnt;
  rec_t exp_q[$];
  rec_t got_q[$];
  vec_t vecs[6];

  receiver_engine_if bus();

  receiver_engine #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    tick_cnt        = 0;
    bus.sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_cnt        = tick_cnt + 1;
      bus.sample_tick = (tick_cnt % 4 == 0);
    end
  end

  // Capture every cycle rx_valid is high; a stretched pulse shows up as an extra record.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rx_valid === 1'b1) begin
        got_q.push_back('{bus.data_out, bus.parity_err, bus.frame_err});
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold_bit(input logic b);
    bus.RX = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p_ok, input logic stop);
    logic p;
    p = p_ok ? ~^d : ^d;
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
    hold_bit(p);
    hold_bit(stop);
  endtask

  // Reference model: expectation from the bits that were put on the line.
  function automatic rec_t model(input logic [7:0] d, input logic p_ok, input logic stop);
    logic p;
    rec_t r;
    p      = p_ok ? ~^d : ^d;
    r.data = d;
    r.perr = ($countones({d, p}) % 2 == 0);
    r.ferr = ~stop;
    return r;
  endfunction

  task automatic compare_frames(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({name, "_data"}, got_q[i].data, exp_q[i].data);
      check({name, "_perr"}, got_q[i].perr, exp_q[i].perr);
      check({name, "_ferr"}, got_q[i].ferr, exp_q[i].ferr);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.RX = 1'b1;
    reset  = 1'b1;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[5] = '{8'h6B, 1'b0, 1'b0, 8'h6B, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_data", bus.data_out, 8'h00);
    check("rst_valid", bus.rx_valid, 1'b0);
    check("rst_perr", bus.parity_err, 1'b0);
    check("rst_ferr", bus.frame_err, 1'b0);
    check("rst_busy", bus.rx_busy, 1'b0);
    reset = 1'b0;
    hold_bit(1'b1);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].p_ok, vecs[i].stop);
      hold_bit(1'b1);
      hold_bit(1'b1);
      exp_q.push_back('{vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr});
      compare_frames("table");
      check("table_busy_after", bus.rx_busy, 1'b0);
    end

    // Stop bit low, line held low: exactly one frame, engine stays busy until RX rises.
    send_frame(8'h3C, 1'b1, 1'b0);
    hold_bit(1'b0);
    hold_bit(1'b0);
    hold_bit(1'b0);
    check("break_frames", got_q.size(), 1);
    check("break_busy", bus.rx_busy, 1'b1);
    hold_bit(1'b1);
    check("break_release_busy", bus.rx_busy, 1'b0);
    send_frame(8'h81, 1'b1, 1'b1);
    hold_bit(1'b1);
    exp_q.push_back('{8'h3C, 1'b0, 1'b1});
    exp_q.push_back('{8'h81, 1'b0, 1'b0});
    compare_frames("break");

    // Short low glitch: busy pulses, no frame.
    bus.RX = 1'b0;
    repeat (20) @(negedge clk);
    bus.RX = 1'b1;
    check("glitch_busy_high", bus.rx_busy, 1'b1);
    hold_bit(1'b1);
    check("glitch_busy_low", bus.rx_busy, 1'b0);
    check("glitch_no_frame", got_q.size(), 0);
    send_frame(8'h55, 1'b1, 1'b1);
    hold_bit(1'b1);
    exp_q.push_back('{8'h55, 1'b0, 1'b0});
    compare_frames("glitch");

    // Back-to-back frames with no idle gap.
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFE, 1'b1, 1'b1);
    hold_bit(1'b1);
    exp_q.push_back('{8'h01, 1'b0, 1'b0});
    exp_q.push_back('{8'hFE, 1'b0, 1'b0});
    compare_frames("b2b");

    // Reset in the middle of D4: partial frame dropped, outputs cleared at once.
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(1'b1);
    bus.RX = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    check("midrst_busy_before", bus.rx_busy, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_data", bus.data_out, 8'h00);
    check("midrst_valid", bus.rx_valid, 1'b0);
    check("midrst_perr", bus.parity_err, 1'b0);
    check("midrst_ferr", bus.frame_err, 1'b0);
    check("midrst_busy", bus.rx_busy, 1'b0);
    bus.RX = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    hold_bit(1'b1);
    send_frame(8'h7E, 1'b1, 1'b1);
    hold_bit(1'b1);
    exp_q.push_back('{8'h7E, 1'b0, 1'b0});
    compare_frames("midrst");

    // Random frames against the reference model.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic       p_ok;
      logic       stop;
      int         gap;
      d    = 8'($urandom);
      p_ok = ($urandom_range(0, 3) != 0);
      stop = ($urandom_range(0, 4) != 0);
      gap  = stop ? $urandom_range(0, 1) : 1 + $urandom_range(0, 1);
      send_frame(d, p_ok, stop);
      for (int g = 0; g < gap; g++) hold_bit(1'b1);
      exp_q.push_back(model(d, p_ok, stop));
    end
    hold_bit(1'b1);
    hold_bit(1'b1);
    compare_frames("random");
    check("random_busy_after", bus.rx_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
